cla_slice_sequencer: RTL
========================

// Module: cla_slice_sequencer
// PURPOSE
//  Multi-cycle wide add/subtract controller. Time-shares one SLICE-bit carry-lookahead adder
//  across a WIDTH-bit operation, one slice per cycle, LSB slice first.
//  Slice carry-out is registered and fed forward as the next slice's carry-in.
//  Sits between the ALU issue logic (valid/ready request side) and the result writeback (valid/ready).
// PARAMETERS
//  WIDTH  64  operand/result width; must be an integer multiple of SLICE (elaboration error otherwise)
//  SLICE  16  bits added per cycle; multiple of 4 (built from 4-bit lookahead groups)
//  NS = WIDTH/SLICE (derived localparam, >=1)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid & in_ready at a rising edge
//  op_sub     in   1      0: A+B; 1: A-B (A + ~B + 1)
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  out_valid  out  1      result valid
//  out_ready  in   1      result consumed when out_valid & out_ready at a rising edge
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      final carry out (for sub: 1 = no borrow)
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset (rst_n low at edge): state IDLE, slice index 0, carry reg 0, operand regs 0,
//    sum 0, cout 0, ovf 0, zero 0, out_valid 0. in_ready = (state==IDLE), so 1 from the first edge after reset.
//  - Reset dominates every other event, including mid-RUN and mid-DONE; in-flight op is discarded silently.
//  - FSM: IDLE -> RUN on accept; RUN -> DONE after slice NS-1 processed; DONE -> IDLE on out_valid & out_ready.
//  - IDLE: in_ready=1, out_valid=0. On accept: latch op_a, (op_sub ? ~op_b : op_b), carry reg = op_sub, idx=0.
//  - RUN: in_ready=0. Each edge: sum[idx*SLICE +: SLICE] <= slice sum of latched A/B slice + carry reg;
//    carry reg <= slice carry out; idx++. Inputs on op_* / in_valid are ignored.
//  - On the edge processing idx=NS-1: cout, ovf (from that slice's bit SLICE-1 carry-in/out), zero
//    (whole assembled sum) registered; state DONE; out_valid=1.
//  - Latency: out_valid rises exactly NS edges after the accept edge (NS=1: next edge).
//  - DONE: out_valid=1, in_ready=0; sum/cout/ovf/zero held stable until handshake. No same-cycle
//    re-accept: after handshake edge, IDLE for >=1 cycle. Back-to-back throughput: 1 op per NS+2 cycles.
//  - out_valid falls on the handshake edge; sum/flags keep last value until the next op overwrites them.
//  - No accept when in_valid is X-free low; in_valid high while in_ready low has no effect and need not be held.
//  - Wrap-around: all arithmetic modulo 2^WIDTH; carry out of the top slice goes only to cout.
//  - idx width = max(1, clog2(NS)); idx never exceeds NS-1.
// TESTING (WIDTH=64, SLICE=16, NS=4)
//  1. add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> out_valid 4 edges after accept; sum 0, cout 1, zero 1, ovf 0
//     (carry ripples through all 4 slices).
//  2. sub 0x5 - 0x7 -> sum 0xFFFF_FFFF_FFFF_FFFE, cout 0, ovf 0, zero 0; sub 0x7 - 0x7 -> sum 0, cout 1, zero 1.
//  3. add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> sum 0x8000_0000_0000_0000, ovf 1, cout 0;
//     sub 0x8000_0000_0000_0000 - 0x1 -> sum 0x7FFF_FFFF_FFFF_FFFF, ovf 1, cout 1.
//  4. Backpressure: out_ready low 10 cycles in DONE while in_valid pulses with new operands ->
//     out_valid stays 1, sum/flags unchanged, in_ready 0, new request not taken.
//  5. rst_n low for one edge during RUN (idx=2) -> next cycle out_valid 0, sum 0, flags 0, in_ready 1;
//     a fresh 0x1 + 0x2 then returns sum 0x3 with exactly 4-edge latency.
//  6. in_valid and out_ready tied 1, operands randomised -> accepts every 6 cycles, each result matches
//     the 64-bit reference model; 1000 ops, zero mismatches.

Source files
------------

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract that time-shares one SLICE-bit carry-lookahead
// adder, LSB slice first, with the slice carry registered between cycles.
module cla_slice_sequencer #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NS    = WIDTH / SLICE;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

  if ((WIDTH % SLICE) != 0 || (SLICE % 4) != 0 || NS < 1) begin : g_bad_param
    $error("cla_slice_sequencer: WIDTH must be a multiple of SLICE, SLICE a multiple of 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nxt;
  logic             carry_q, cout_q, ovf_q, zero_q;
  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE+1:0] sl_res;
  logic             accept, last_slice;

  // Returns {carry into bit SLICE-1, carry out, sum}; 4-bit lookahead groups rippled.
  function automatic logic [SLICE+1:0] cla_add(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
    logic [SLICE-1:0] g, p;
    logic [SLICE:0]   c;
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = cin;
    for (int k = 0; k < SLICE; k += 4) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
             | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
             | (p[k+3] & p[k+2] & p[k+1] & g[k])
             | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
    end
    return {c[SLICE-1], c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  assign a_sl       = a_q[idx*SLICE +: SLICE];
  assign b_sl       = b_q[idx*SLICE +: SLICE];
  assign sl_res     = cla_add(a_sl, b_sl, carry_q);
  assign last_slice = (idx == IDX_W'(NS - 1));
  assign accept     = in_valid && in_ready;

  always_comb begin
    sum_nxt = sum_q;
    sum_nxt[idx*SLICE +: SLICE] = sl_res[SLICE-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN:  if (last_slice) state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch on accept, then one slice per cycle; flags captured with the top slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= op_sub ? ~op_b : op_b;
      carry_q <= op_sub;
      idx     <= '0;
    end else if (state == S_RUN) begin
      sum_q   <= sum_nxt;
      carry_q <= sl_res[SLICE];
      if (last_slice) begin
        cout_q <= sl_res[SLICE];
        ovf_q  <= sl_res[SLICE+1] ^ sl_res[SLICE];
        zero_q <= (sum_nxt == '0);
        idx    <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
